// File: rtl/display_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_decoder_pkg
// Description : Shared 7-segment encodings and value types for the 0..19
//               display driver and its read-back decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package display_decoder_pkg;

    // Segment pattern {g,f,e,d,c,b,a}, active-high
    typedef logic [6:0] seg7_t;
    // Recovered display value 0..19
    typedef logic [4:0] bcd_t;

    localparam seg7_t SEG_0     = 7'h3F;
    localparam seg7_t SEG_1     = 7'h06;
    localparam seg7_t SEG_2     = 7'h5B;
    localparam seg7_t SEG_3     = 7'h4F;
    localparam seg7_t SEG_4     = 7'h66;
    localparam seg7_t SEG_5     = 7'h6D;
    localparam seg7_t SEG_6     = 7'h7D;
    localparam seg7_t SEG_7     = 7'h07;
    localparam seg7_t SEG_8     = 7'h7F;
    localparam seg7_t SEG_9     = 7'h6F;
    localparam seg7_t SEG_BLANK = 7'h00;

    // Combine the tens indicator and a units digit into the 5-bit value.
    // Largest result is 19, so 5 bits never wrap.
    function automatic bcd_t make_value(input logic tens, input logic [3:0] digit);
        make_value = (tens ? 5'd10 : 5'd0) + {1'b0, digit};
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_decoder_19_seg7_to_digit.sv
`default_nettype none
// ============================================================================
// Module      : seg7_to_digit
// Description : Combinational map from a 7-segment pattern to a decimal
//               digit, with flags for legal digit and blank display.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_to_digit
    import display_decoder_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] digit_o,
    output logic       legal_o,
    output logic       blank_o
);

    // Pattern lookup; anything not a digit or blank is illegal
    always_comb begin
        digit_o = 4'd0;
        legal_o = 1'b1;
        blank_o = 1'b0;
        case (seg_i)
            SEG_0:     digit_o = 4'd0;
            SEG_1:     digit_o = 4'd1;
            SEG_2:     digit_o = 4'd2;
            SEG_3:     digit_o = 4'd3;
            SEG_4:     digit_o = 4'd4;
            SEG_5:     digit_o = 4'd5;
            SEG_6:     digit_o = 4'd6;
            SEG_7:     digit_o = 4'd7;
            SEG_8:     digit_o = 4'd8;
            SEG_9:     digit_o = 4'd9;
            SEG_BLANK: begin
                legal_o = 1'b0;
                blank_o = 1'b1;
            end
            default:   legal_o = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/display_decoder_19.sv
`default_nettype none
// ============================================================================
// Module      : display_decoder_19
// Description : Reads a driven 0..19 seven-segment display back into binary.
//               Inputs are synchronized, must hold steady for STABLE_CYCLES
//               samples, and each stable pattern is accepted once. Result is
//               offered on a valid/ack handshake with error/overrun flags.
// Revision    : 1.0 - initial release
// ============================================================================
module display_decoder_19
    import display_decoder_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
)(
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] PORT_DISPLAY,
    input  logic       SET_ON_DISPLAY_DEC,
    input  logic       PORT_ACK,
    output logic [4:0] PORT_BCD,
    output logic       VALID,
    output logic       ERROR,
    output logic       OVERRUN
);

    // Count at which a pattern has been seen STABLE_CYCLES times in a row
    localparam logic [3:0] c_cnt_last = 4'(STABLE_CYCLES - 1);

    logic [7:0] sync1_q, sync2_q;
    logic [7:0] prev_q, prev_d;
    logic [3:0] cnt_q, cnt_d;
    logic       armed_q, armed_d;
    bcd_t       bcd_q, bcd_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;
    logic       overrun_q, overrun_d;

    logic [7:0] smp;
    logic       accept;
    logic [3:0] digit;
    logic       legal;
    logic       blank;

    assign smp = sync2_q;

    // Fires once per stable pattern; armed is re-enabled only by a change
    assign accept = (smp == prev_q) && (cnt_q == c_cnt_last) && armed_q;

    seg7_to_digit u_seg7_to_digit (
        .seg_i   (prev_q[6:0]),
        .digit_o (digit),
        .legal_o (legal),
        .blank_o (blank)
    );

    // Two-flop synchronizer on {tens, segments}
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 8'd0;
            sync2_q <= 8'd0;
        end else begin
            sync1_q <= {SET_ON_DISPLAY_DEC, PORT_DISPLAY};
            sync2_q <= sync1_q;
        end
    end

    // Stability tracker next state: restart on change, saturate the count
    always_comb begin
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (smp != prev_q) begin
            prev_d  = smp;
            cnt_d   = 4'd0;
            armed_d = 1'b1;
        end else begin
            if (cnt_q < c_cnt_last) begin
                cnt_d = cnt_q + 4'd1;
            end
            if (accept) begin
                armed_d = 1'b0;
            end
        end
    end

    // Output/handshake next state; a legal accept overrides a same-cycle ack
    always_comb begin
        bcd_d     = bcd_q;
        valid_d   = valid_q;
        error_d   = error_q;
        overrun_d = overrun_q;
        if (PORT_ACK && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (accept) begin
            if (legal) begin
                bcd_d     = make_value(prev_q[7], digit);
                valid_d   = 1'b1;
                error_d   = 1'b0;
                overrun_d = valid_q && !PORT_ACK;
            end else if (blank && !prev_q[7]) begin
                error_d = 1'b0;
            end else begin
                error_d = 1'b1;
            end
        end
    end

    // State registers for tracker and outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_q    <= 8'd0;
            cnt_q     <= 4'd0;
            armed_q   <= 1'b1;
            bcd_q     <= 5'd0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            overrun_q <= overrun_d;
        end
    end

    assign PORT_BCD = bcd_q;
    assign VALID    = valid_q;
    assign ERROR    = error_q;
    assign OVERRUN  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_display_decoder_19.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_decoder_19
// Description : Scoreboard bench for display_decoder_19. Stimulus pushes the
//               expected output tuple and the edge it should appear on; a
//               monitor pops an entry whenever the output tuple changes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_decoder_19;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [6:0] PORT_DISPLAY = 7'h00;
    logic       SET_ON_DISPLAY_DEC = 1'b0;
    logic       PORT_ACK = 1'b0;
    logic [4:0] PORT_BCD;
    logic       VALID;
    logic       ERROR;
    logic       OVERRUN;

    display_decoder_19 #(.STABLE_CYCLES(4)) dut (
        .CLK                (CLK),
        .RST                (RST),
        .PORT_DISPLAY       (PORT_DISPLAY),
        .SET_ON_DISPLAY_DEC (SET_ON_DISPLAY_DEC),
        .PORT_ACK           (PORT_ACK),
        .PORT_BCD           (PORT_BCD),
        .VALID              (VALID),
        .ERROR              (ERROR),
        .OVERRUN            (OVERRUN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] tup;      // {bcd, valid, error, overrun}
        int         at_edge;  // -1 = timing not checked
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   t0 = 0;
    bit   mon_en = 1'b0;
    logic [7:0] last_tup = 8'd0;

    // Hand-written driver patterns for 0..9
    logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    // Monitor: every change of the output tuple must match the queue head
    always @(negedge CLK) begin
        logic [7:0] cur;
        exp_t e;
        cur = {PORT_BCD, VALID, ERROR, OVERRUN};
        if (mon_en && cur !== last_tup) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: got bcd=%0d v=%b e=%b o=%b at edge %0d, required no change",
                         cur[7:3], cur[2], cur[1], cur[0], edge_cnt);
            end else begin
                e = q.pop_front();
                if (cur !== e.tup || (e.at_edge >= 0 && edge_cnt != e.at_edge)) begin
                    n_bad++;
                    $display("FAIL output_event: got bcd=%0d v=%b e=%b o=%b at edge %0d, required bcd=%0d v=%b e=%b o=%b at edge %0d",
                             cur[7:3], cur[2], cur[1], cur[0], edge_cnt,
                             e.tup[7:3], e.tup[2], e.tup[1], e.tup[0], e.at_edge);
                end
            end
        end
        last_tup = cur;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [6:0] seg, input logic dec);
        PORT_DISPLAY       = seg;
        SET_ON_DISPLAY_DEC = dec;
        t0                 = edge_cnt;
    endtask

    task automatic push(input logic [4:0] bcd, input logic v, input logic e,
                        input logic o, input int at);
        exp_t x;
        x.tup     = {bcd, v, e, o};
        x.at_edge = at;
        q.push_back(x);
    endtask

    // One-cycle ack pulse; VALID and OVERRUN drop on the sampling edge
    task automatic ack_now(input logic [4:0] bcd);
        PORT_ACK = 1'b1;
        push(bcd, 1'b0, 1'b0, 1'b0, edge_cnt + 1);
        tick(1);
        PORT_ACK = 1'b0;
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if ({PORT_BCD, VALID, ERROR, OVERRUN} !== 8'd0) begin
            n_bad++;
            $display("FAIL %s: got bcd=%0d v=%b e=%b o=%b, required all zero",
                     name, PORT_BCD, VALID, ERROR, OVERRUN);
        end
    endtask

    initial begin
        // Power-on reset; all-zero samples afterwards are a silent blank
        #1 RST = 1'b1;
        tick(3);
        check_zero("reset_state");
        RST = 1'b0;
        mon_en = 1'b1;
        tick(10);

        // Sweep 0..19, ack after each VALID
        for (int v = 0; v < 20; v++) begin
            drive(seg_tab[v % 10], (v >= 10));
            push(5'(v), 1'b1, 1'b0, 1'b0, t0 + 7);
            tick(7);
            ack_now(5'(v));
            tick(2);
        end

        // Glitch: 3-cycle 8 between steady 7s is never accepted
        drive(7'h07, 1'b0);
        push(5'd7, 1'b1, 1'b0, 1'b0, t0 + 7);
        tick(7);
        ack_now(5'd7);
        tick(2);
        drive(7'h7F, 1'b0);
        tick(3);
        drive(7'h07, 1'b0);
        push(5'd7, 1'b1, 1'b0, 1'b0, t0 + 7);   // return to 7 is a new stable pattern
        tick(7);
        ack_now(5'd7);
        tick(2);
        // 6-cycle 8 is long enough
        drive(7'h7F, 1'b0);
        push(5'd8, 1'b1, 1'b0, 1'b0, t0 + 7);
        tick(6);
        drive(7'h07, 1'b0);
        tick(1);
        ack_now(5'd8);
        push(5'd7, 1'b1, 1'b0, 1'b0, t0 + 7);
        tick(5);
        ack_now(5'd7);
        tick(2);

        // Illegal pattern, blank cases, then a legal tens value
        drive(7'h49, 1'b0);
        push(5'd7, 1'b0, 1'b1, 1'b0, t0 + 7);
        tick(10);
        drive(7'h00, 1'b0);
        push(5'd7, 1'b0, 1'b0, 1'b0, t0 + 7);
        tick(10);
        drive(7'h00, 1'b1);
        push(5'd7, 1'b0, 1'b1, 1'b0, t0 + 7);
        tick(10);
        drive(7'h06, 1'b1);
        push(5'd11, 1'b1, 1'b0, 1'b0, t0 + 7);
        tick(7);
        ack_now(5'd11);
        tick(2);

        // Overrun: 5 left unacked, then 13
        drive(7'h6D, 1'b0);
        push(5'd5, 1'b1, 1'b0, 1'b0, t0 + 7);
        tick(10);
        drive(7'h4F, 1'b1);
        push(5'd13, 1'b1, 1'b0, 1'b1, t0 + 7);
        tick(7);
        ack_now(5'd13);
        tick(2);

        // Ack coincident with the accept of 19 while overrun is set
        drive(7'h5B, 1'b0);
        push(5'd2, 1'b1, 1'b0, 1'b0, t0 + 7);
        tick(10);
        drive(7'h66, 1'b0);
        push(5'd4, 1'b1, 1'b0, 1'b1, t0 + 7);
        tick(10);
        drive(7'h6F, 1'b1);
        push(5'd19, 1'b1, 1'b0, 1'b0, t0 + 7);
        tick(6);
        PORT_ACK = 1'b1;
        tick(1);
        PORT_ACK = 1'b0;
        tick(3);

        // Async reset at cnt=2 while 19 is still valid
        drive(7'h4F, 1'b0);
        tick(5);
        RST = 1'b1;
        push(5'd0, 1'b0, 1'b0, 1'b0, -1);
        #1;
        check_zero("reset_mid_count");
        tick(2);
        RST = 1'b0;
        push(5'd3, 1'b1, 1'b0, 1'b0, edge_cnt + 7);
        tick(7);
        ack_now(5'd3);
        tick(5);

        // Every expected event must have been seen
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_events: got %0d outstanding, required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
